// File: rtl/addsub_pkg.sv
// Shared constants and geometry helpers for the pipelined add/sub stream.
// Stage count and latency are derived here so top and bench agree.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nstage(
    input int width,
    input int block
  );
    return (width + block - 1) / block;
  endfunction

  function automatic int lat(
    input int ns,
    input int reg_in,
    input int reg_out
  );
    return ns - 1 + reg_in + reg_out;
  endfunction

endpackage

// File: rtl/addsub_slice_stage.sv
// One carry-chain slice: adds bits [LO +: SW] of the travelling words,
// optionally registering the merged word, carry, MSB carry and valid.
module addsub_slice_stage #(
  parameter int WIDTH = 16,
  parameter int LO    = 0,
  parameter int SW    = 4,
  parameter bit REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_c,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic             o_c,
  output logic             o_cmsb
);

  logic [SW:0]      w_add;
  logic [SW-1:0]    w_s;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cmsb;

  assign w_add = {1'b0, i_x[LO +: SW]}
               + {1'b0, i_y[LO +: SW]}
               + {{SW{1'b0}}, i_c};
  assign w_s   = w_add[SW-1:0];

  // carry into the slice MSB recovered from its sum bit
  assign w_cmsb = i_x[LO+SW-1]
                ^ i_y[LO+SW-1]
                ^ w_s[SW-1];

  // x carries sum below/at this slice, operand A above
  always_comb begin
    w_x = i_x;
    w_x[LO +: SW] = w_s;
    w_y = i_y;
    w_y[LO +: SW] = '0;
  end

  generate
    if (REG) begin : g_reg
      logic             r_v;
      logic             r_c;
      logic             r_m;
      logic [WIDTH-1:0] r_x;
      logic [WIDTH-1:0] r_y;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
          r_c <= 1'b0;
          r_m <= 1'b0;
          r_x <= '0;
          r_y <= '0;
        end else if (i_en) begin
          r_v <= i_valid;
          r_c <= w_add[SW];
          r_m <= w_cmsb;
          r_x <= w_x;
          r_y <= w_y;
        end
      end

      assign o_valid = r_v;
      assign o_c     = r_c;
      assign o_cmsb  = r_m;
      assign o_x     = r_x;
      assign o_y     = r_y;
    end else begin : g_comb
      assign o_valid = i_valid;
      assign o_c     = w_add[SW];
      assign o_cmsb  = w_cmsb;
      assign o_x     = w_x;
      assign o_y     = w_y;
    end
  endgenerate

endmodule

// File: rtl/pipelined_addsub_stream.sv
// Block-carry pipelined add/sub with valid/ready backpressure.
// One global enable stalls every register while the output is held.
module pipelined_addsub_stream
  import addsub_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int BLOCK   = 4,
  parameter int REG_IN  = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = nstage(WIDTH, BLOCK);
  localparam int LAT    = lat(NSTAGE, REG_IN, REG_OUT);

  generate
    if (LAT < 1 || BLOCK < 1 || BLOCK > WIDTH) begin : g_bad
      $error("pipelined_addsub_stream: illegal geometry LAT=%0d", LAT);
    end
  endgenerate

  logic             w_en;
  logic             w_iv;
  logic             w_cx;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_x [NSTAGE+1];
  logic [WIDTH-1:0] w_y [NSTAGE+1];
  logic             w_c [NSTAGE+1];
  logic             w_v [NSTAGE+1];
  logic             w_m [NSTAGE];

  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en & ~rst;
  assign w_iv     = in_valid & in_ready;

  // subtract folds into add: a + ~b + ~cin
  assign w_bx = (op == OP_ADD) ? b : ~b;
  assign w_cx = (op == OP_SUB) ? ~cin : cin;

  generate
    if (REG_IN != 0) begin : g_in
      logic             r_v;
      logic             r_c;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
          r_c <= 1'b0;
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_v <= w_iv;
          r_c <= w_cx;
          r_a <= a;
          r_b <= w_bx;
        end
      end

      assign w_v[0] = r_v;
      assign w_c[0] = r_c;
      assign w_x[0] = r_a;
      assign w_y[0] = r_b;
    end else begin : g_noin
      assign w_v[0] = w_iv;
      assign w_c[0] = w_cx;
      assign w_x[0] = a;
      assign w_y[0] = w_bx;
    end
  endgenerate

  // last slice's register doubles as the output boundary register
  genvar s;
  generate
    for (s = 0; s < NSTAGE; s++) begin : g_st
      localparam int LO = s * BLOCK;
      localparam int SW = (s == NSTAGE-1) ? WIDTH - LO : BLOCK;
      localparam bit RG = (s == NSTAGE-1) ? (REG_OUT != 0) : 1'b1;

      addsub_slice_stage #(
        .WIDTH (WIDTH),
        .LO    (LO),
        .SW    (SW),
        .REG   (RG)
      ) u_st (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (w_v[s]),
        .i_x     (w_x[s]),
        .i_y     (w_y[s]),
        .i_c     (w_c[s]),
        .o_valid (w_v[s+1]),
        .o_x     (w_x[s+1]),
        .o_y     (w_y[s+1]),
        .o_c     (w_c[s+1]),
        .o_cmsb  (w_m[s])
      );
    end
  endgenerate

  assign out_valid = w_v[NSTAGE];
  assign sum       = w_x[NSTAGE];
  assign cout      = w_c[NSTAGE];
  assign ovf       = w_c[NSTAGE] ^ w_m[NSTAGE-1];

endmodule
